// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage LEGv8 pipeline: load-use stall,
// taken-branch IF/ID squash, memory-wait freeze, and saturating
// stall/flush performance counters.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_rn/id_rm/id_uses_* decoded ID-stage source operands
//   ex_rd/ex_memread      EX-stage destination and load flag
//   branch_taken          EX resolved a taken branch this cycle
//   mem_wait              data memory not ready, freeze everything
//   pc_write_en, ifid_write_en, idex_write_en   pipeline write enables
//   idex_bubble, ifid_flush                     NOP insertion controls
//   stall_count, flush_count                    performance counters
module hazard_stall_unit #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             branch_taken,
   input  logic             mem_wait,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             idex_write_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu;

   // X31 reads as zero, so a load targeting it can never feed a consumer.
   assign lu = ex_memread && (ex_rd != 5'd31) &&
               ((id_uses_rn && (ex_rd == id_rn)) ||
                (id_uses_rm && (ex_rd == id_rm)));

   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_write_en = 1'b1;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b0;

      if (reset) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_write_en = 1'b0;
         idex_bubble   = 1'b1;
         ifid_flush    = 1'b1;
         state_d       = RUN;
         fcnt_d        = 3'd0;
         stall_cnt_d   = '0;
         flush_cnt_d   = '0;
      end else if (mem_wait) begin
         // Freeze: branch/lu are held stable upstream and re-seen later.
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_write_en = 1'b0;
      end else if (branch_taken) begin
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
         if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
         end
         // This cycle is already the first squash cycle.
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_INIT;
         end else begin
            state_d = RUN;
            fcnt_d  = 3'd0;
         end
      end else if (state_q == FLUSH) begin
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
         if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
         end else begin
            fcnt_d = fcnt_q - 3'd1;
         end
      end else if (lu) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_bubble   = 1'b1;
         if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         fcnt_q      <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage LEGv8 CPU. It handles the hazards that data/flag forwarding cannot resolve: load-use stalls, wrong-path squash after a taken branch, and whole-pipeline freeze on a memory wait. It drives the PC, IF/ID and ID/EX write enables, bubble and flush controls, and keeps saturating stall/flush performance counters. It sits beside the forwarding unit and sees the decoded ID-stage and EX-stage register fields.

## Interface
- FLUSH_CYCLES, 1: cycles of IF/ID squash after a taken branch (legal 1..7).
- CNT_W, 16: width of each performance counter.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_rn  in  5  Rn field of the instruction in ID.
- id_rm  in  5  Rm/Rt field of the instruction in ID.
- id_uses_rn  in  1  ID instruction reads Rn.
- id_uses_rm  in  1  ID instruction reads Rm/Rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  EX instruction is LDUR.
- branch_taken  in  1  EX resolved a taken branch or CBZ/CBNZ this cycle.
- mem_wait  in  1  data memory not ready; freeze the pipeline.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF/ID register may update.
- idex_write_en  out  1  ID/EX register may update.
- idex_bubble  out  1  load zero controls into ID/EX (NOP).
- ifid_flush  out  1  load NOP into IF/ID.
- stall_count  out  CNT_W  load-use stall cycles since reset.
- flush_count  out  CNT_W  taken-branch flush events since reset.

## Operation
- States: RUN, FLUSH. Registered flush counter fcnt has 3 bits.
- Load-use detect (lu):
  - ex_memread && ex_rd != 31 && ((id_uses_rn && ex_rd == id_rn) || (id_uses_rm && ex_rd == id_rm)).
  - Combinational, same cycle.
- Priority per cycle: reset > mem_wait > branch_taken > FLUSH state > lu > normal.
- reset:
  - Outputs: pc_write_en = ifid_write_en = idex_write_en = 0, idex_bubble = 1, ifid_flush = 1.
  - Next state RUN, fcnt = 0, both counters = 0.
- mem_wait = 1:
  - All three write enables 0; idex_bubble = 0; ifid_flush = 0.
  - State, fcnt and counters hold.
  - branch_taken and lu are ignored that cycle. The upstream holds them stable, so they are re-evaluated when mem_wait drops.
- branch_taken (in any state):
  - Outputs: pc_write_en = 1, ifid_write_en = 1, idex_write_en = 1, ifid_flush = 1, idex_bubble = 1.
  - flush_count increments (saturating).
  - If FLUSH_CYCLES > 1: next state FLUSH with fcnt = FLUSH_CYCLES-1. Otherwise stay RUN.
  - A simultaneous lu produces no stall and does not increment stall_count.
- FLUSH state, no branch_taken:
  - Outputs: ifid_flush = 1, idex_bubble = 1, all enables 1.
  - fcnt decrements. When fcnt reaches 1, the next state is RUN (fcnt = 0).
  - lu is suppressed.
- RUN with lu:
  - Outputs: pc_write_en = 0, ifid_write_en = 0, idex_write_en = 1, idex_bubble = 1, ifid_flush = 0.
  - stall_count increments (saturating).
  - One cycle per bubble. The load then leaves EX, so lu deasserts naturally. The forwarding unit supplies the load data from MEM.
- RUN normal: all enables 1, idex_bubble = 0, ifid_flush = 0.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Control outputs are combinational from inputs plus registered state: zero-cycle latency from lu, branch_taken or mem_wait.
- State, fcnt and counters update on the rising clk edge following the cycle of the event.
- Counter values are visible the cycle after the event.
- Load-use cost is exactly 1 bubble cycle per dependent load.
- Taken-branch cost is exactly FLUSH_CYCLES cycles of ifid_flush, excluding mem_wait cycles.
- Reset asserted mid-FLUSH: FLUSH is abandoned on that edge. The first post-reset cycle is RUN with normal outputs.
- X31 (XZR) never causes a stall.

## Test plan
- Load-use on Rn:
  - Stimulus: ex_memread = 1, ex_rd = 5, id_rn = 5, id_uses_rn = 1.
  - Response: that cycle pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
  - Next cycle (ex_memread = 0): all enables 1; stall_count = 1.
- XZR and unused operand:
  - Stimulus: ex_rd = 31 = id_rn; or ex_rd = 7 = id_rm with id_uses_rm = 0.
  - Response: no stall; stall_count stays 0.
- Branch over load-use:
  - Stimulus: branch_taken = 1 and lu true in the same cycle, FLUSH_CYCLES = 1.
  - Response: ifid_flush = 1, idex_bubble = 1, pc_write_en = 1; flush_count = 1, stall_count = 0; RUN next cycle.
- Multi-cycle flush with memory wait:
  - Stimulus: FLUSH_CYCLES = 3; branch_taken for 1 cycle, then mem_wait = 1 for 2 cycles.
  - Response: ifid_flush high for 3 non-wait cycles total. During wait, enables 0 and fcnt held. RUN after the 3rd flush cycle.
- Counter saturation:
  - Stimulus: CNT_W = 4; 20 consecutive load-use events separated by normal cycles.
  - Response: stall_count stops at 15.
- Reset mid-flush:
  - Stimulus: FLUSH_CYCLES = 4; assert reset on the 2nd flush cycle.
  - Response: during reset, enables 0, idex_bubble = 1, ifid_flush = 1. After release, RUN with normal outputs; counters 0.
